// File: rtl/sram_like_arbiter.sv
// N-channel arbiter from SRAM-like master ports onto one shared SRAM-like memory port.
// Accepted transactions are tracked in an in-order ID FIFO so each response returns to its issuer.
module sram_like_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [2*NUM_CH-1:0]        ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_addr_ok,
  output logic [NUM_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];
  logic [1:0]        size_arr  [NUM_CH];

  logic [CH_W-1:0]  fifo_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_q, lock_d;
  logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic [CH_W-1:0]  winner, grant, head;
  logic             any_req, not_full, accept, respond, stray;

  // First requester at or after start, scanning upward with wrap.
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] req,
                                           input logic [CH_W-1:0]   start);
    logic [CH_W-1:0] res;
    logic [CH_W-1:0] cand;
    logic            found;
    int              idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!found && req[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign addr_arr[gi]   = ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = ch_wdata[gi*DATA_W +: DATA_W];
      assign size_arr[gi]   = ch_size[gi*2 +: 2];
      assign ch_addr_ok[gi] = accept  & (grant == CH_W'(gi));
      assign ch_data_ok[gi] = respond & (head  == CH_W'(gi));
    end
  endgenerate

  // A stalled request keeps its channel so the memory side sees a stable request.
  always_comb begin
    winner   = pick(ch_req, (RR_MODE != 0) ? rr_ptr_q : '0);
    grant    = lock_q ? lock_ch_q : winner;
    any_req  = lock_q ? ch_req[lock_ch_q] : |ch_req;
    not_full = count_q < CNT_W'(MAX_OUT);
    mem_req  = not_full & any_req;
    accept   = mem_req & mem_addr_ok;
    head     = fifo_mem[rd_ptr_q];
    respond  = mem_data_ok & (count_q != '0);
    stray    = mem_data_ok & (count_q == '0);
  end

  assign mem_wr    = ch_wr[grant];
  assign mem_size  = size_arr[grant];
  assign mem_addr  = addr_arr[grant];
  assign mem_wdata = wdata_arr[grant];
  assign ch_rdata  = mem_rdata;
  assign err       = err_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      lock_d   = 1'b0;
      if (RR_MODE != 0)
        rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end else if (mem_req) begin
      lock_d    = 1'b1;
      lock_ch_d = grant;
    end
    if (respond) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(accept) - CNT_W'(respond);
    err_d   = err_q | stray;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  // ID storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_q] <= grant;
  end

endmodule
